// File: rtl/testbench_ls_input_poller.sv
// Periodic poller for an 8-bit input PIO: change events {previous, new} are queued in a FIFO with irq and sticky overflow.
// Optional macro TESTBENCH_LS_INPUT_POLLER_DEBOUNCE_EN accepts a sample only after two consecutive equal polls.
module testbench_ls_input_poller #(
  parameter int POLL_DIV   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [1:0]  pio_address,
  input  logic [31:0] pio_readdata,
  output logic        evt_valid,
  output logic [15:0] evt_data,
  input  logic        evt_ready,
  output logic        irq,
  output logic        overflow,
  input  logic        ovf_clear,
  output logic [1:0]  dbg_state,
  output logic [4:0]  dbg_fifo_count
);

  // Handshake: the head event transfers on any rising clk edge where evt_valid && evt_ready;
  // evt_valid never depends on evt_ready, and a pop with evt_valid=0 is ignored.

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] POLL_LAST = 16'(POLL_DIV - 1);
  localparam logic [AW:0] CNT_FULL  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0] CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADDR   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_SAMPLE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      poll_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      poll_cnt_q <= poll_cnt_d;
    end
  end

  // Once a poll leaves IDLE it runs to completion regardless of enable.
  always_comb begin
    state_d     = state_q;
    poll_cnt_d  = poll_cnt_q;
    pio_address = 2'b11;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          if (poll_cnt_q == POLL_LAST) begin
            poll_cnt_d = '0;
            state_d    = ST_ADDR;
          end else begin
            poll_cnt_d = poll_cnt_q + 16'd1;
          end
        end
      end
      ST_ADDR: begin
        pio_address = 2'b00;
        state_d     = ST_WAIT;
      end
      ST_WAIT:   state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign dbg_state = state_q;

  logic [7:0] sample;
  logic       sample_strobe;
  logic       accept;
  logic       unused_readdata;

  assign sample          = pio_readdata[7:0];
  assign sample_strobe   = (state_q == ST_SAMPLE);
  assign unused_readdata = ^pio_readdata[31:8];

`ifdef TESTBENCH_LS_INPUT_POLLER_DEBOUNCE_EN
  logic [7:0] raw_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      raw_q <= '0;
    end else if (sample_strobe) begin
      raw_q <= sample;
    end
  end

  assign accept = sample_strobe && (sample == raw_q);
`else
  assign accept = sample_strobe;
`endif

  logic       first_q;
  logic [7:0] last_q;
  logic       push_req, push, pop, full, drop;

  // The first accepted sample only establishes the baseline.
  always_ff @(posedge clk) begin
    if (reset) begin
      first_q <= 1'b1;
      last_q  <= '0;
    end else if (accept) begin
      first_q <= 1'b0;
      last_q  <= sample;
    end
  end

  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  assign push_req = accept && !first_q && (sample != last_q);
  assign pop      = evt_valid && evt_ready;
  assign full     = (count_q == CNT_FULL);
  assign drop     = push_req && full && !pop;
  assign push     = push_req && !drop;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {last_q, sample};
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // A drop in the same cycle as ovf_clear leaves the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clear) begin
      overflow <= 1'b0;
    end
  end

  assign evt_valid      = (count_q != '0);
  assign evt_data       = mem_q[rd_ptr_q];
  assign irq            = evt_valid;
  assign dbg_fifo_count = 5'(count_q);

endmodule

// File: tb/tb_testbench_ls_input_poller.sv
// Directed bench for testbench_ls_input_poller: poll timing, change events, FIFO full/overflow, reset mid-poll, debounce.
module tb_testbench_ls_input_poller;

  localparam int POLL_DIV   = 16;
  localparam int FIFO_DEPTH = 4;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_SAMPLE = 2'd3;
`ifdef TESTBENCH_LS_INPUT_POLLER_DEBOUNCE_EN
  localparam int EXTRA_POLLS = 1;
`else
  localparam int EXTRA_POLLS = 0;
`endif

  logic        clk;
  logic        reset;
  logic        enable;
  logic [1:0]  pio_address;
  logic [31:0] pio_readdata;
  logic        evt_valid;
  logic [15:0] evt_data;
  logic        evt_ready;
  logic        irq;
  logic        overflow;
  logic        ovf_clear;
  logic [1:0]  dbg_state;
  logic [4:0]  dbg_fifo_count;

  testbench_ls_input_poller #(
    .POLL_DIV  (POLL_DIV),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .pio_address   (pio_address),
    .pio_readdata  (pio_readdata),
    .evt_valid     (evt_valid),
    .evt_data      (evt_data),
    .evt_ready     (evt_ready),
    .irq           (irq),
    .overflow      (overflow),
    .ovf_clear     (ovf_clear),
    .dbg_state     (dbg_state),
    .dbg_fifo_count(dbg_fifo_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [15:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [1:0] st, input string tag);
    int n = 0;
    while (dbg_state !== st && n < 200) begin
      tick();
      n++;
    end
    check_eq({tag, "_reach_state"}, {30'd0, dbg_state}, {30'd0, st});
  endtask

  task automatic wait_sample(input string tag);
    wait_state(ST_SAMPLE, tag);
    tick();
  endtask

  // Leaves the bench in SAMPLE, just before the edge that takes the accepted sample.
  task automatic settle(input logic [7:0] v, input string tag);
    pio_readdata = {24'd0, v};
    for (int i = 0; i < EXTRA_POLLS; i++) wait_sample(tag);
    wait_state(ST_SAMPLE, tag);
  endtask

  task automatic poll_push(input logic [7:0] prev, input logic [7:0] v, input string tag);
    settle(v, tag);
    tick();
    exp_q.push_back({prev, v});
  endtask

  task automatic pop_check(input string tag);
    logic [15:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    check_eq({tag, "_valid"}, {31'd0, evt_valid}, 32'd1);
    check_eq({tag, "_data"}, {16'd0, evt_data}, {16'd0, e});
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask

  initial begin
    int cyc;
    logic seen_addr;
    reset        = 1'b1;
    enable       = 1'b0;
    evt_ready    = 1'b0;
    ovf_clear    = 1'b0;
    pio_readdata = 32'd0;
    repeat (3) tick();

    check_eq("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    check_eq("rst_addr", {30'd0, pio_address}, 32'd3);
    check_eq("rst_valid", {31'd0, evt_valid}, 32'd0);
    check_eq("rst_data", {16'd0, evt_data}, 32'd0);
    check_eq("rst_irq", {31'd0, irq}, 32'd0);
    check_eq("rst_ovf", {31'd0, overflow}, 32'd0);
    check_eq("rst_count", {27'd0, dbg_fifo_count}, 32'd0);

    // constant 0x5A: poll timing, no events
    reset        = 1'b0;
    enable       = 1'b1;
    pio_readdata = 32'h5A;
    cyc = 0;
    while (pio_address !== 2'b00 && cyc < 100) begin tick(); cyc++; end
    check_eq("first_addr_latency", cyc, 16);
    tick();
    check_eq("addr_one_cycle", {30'd0, pio_address}, 32'd3);
    cyc = 1;
    while (pio_address !== 2'b00 && cyc < 100) begin tick(); cyc++; end
    check_eq("poll_period", cyc, 19);
    wait_sample("const");
    wait_sample("const2");
    check_eq("const_no_event", {31'd0, evt_valid}, 32'd0);
    check_eq("const_irq", {31'd0, irq}, 32'd0);

    // single change 5A -> 3C
    settle(8'h3C, "chg");
    check_eq("chg_pre_valid", {31'd0, evt_valid}, 32'd0);
    tick();
    exp_q.push_back(16'h5A3C);
    check_eq("chg_valid_next", {31'd0, evt_valid}, 32'd1);
    check_eq("chg_irq", {31'd0, irq}, 32'd1);
    repeat (3) tick();
    check_eq("chg_irq_held", {31'd0, irq}, 32'd1);
    pop_check("chg_pop");
    check_eq("chg_irq_after_pop", {31'd0, irq}, 32'd0);

    // fill with 01..04, drop 05 with ovf_clear high in the same cycle
    poll_push(8'h3C, 8'h00, "base");
    pop_check("base_pop");
    for (int v = 1; v <= 4; v++) poll_push(8'(v - 1), 8'(v), "fill");
    check_eq("fill_count", {27'd0, dbg_fifo_count}, 32'd4);
    check_eq("fill_ovf", {31'd0, overflow}, 32'd0);
    settle(8'h05, "drop");
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    check_eq("drop_set_wins", {31'd0, overflow}, 32'd1);
    check_eq("drop_count", {27'd0, dbg_fifo_count}, 32'd4);
    for (int i = 0; i < 4; i++) pop_check("drain");
    check_eq("drain_empty", {31'd0, evt_valid}, 32'd0);
    check_eq("ovf_sticky", {31'd0, overflow}, 32'd1);
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    check_eq("ovf_cleared", {31'd0, overflow}, 32'd0);
    poll_push(8'h05, 8'h06, "after_drop");
    pop_check("after_drop_pop");

    // full FIFO with push and pop on the same edge
    for (int v = 7; v <= 10; v++) poll_push(8'(v - 1), 8'(v), "fill2");
    check_eq("fill2_count", {27'd0, dbg_fifo_count}, 32'd4);
    settle(8'h0B, "pushpop");
    check_eq("pushpop_head", {16'd0, evt_data}, {16'd0, exp_q.pop_front()});
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    exp_q.push_back(16'h0A0B);
    check_eq("pushpop_count", {27'd0, dbg_fifo_count}, 32'd4);
    check_eq("pushpop_ovf", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 4; i++) pop_check("drain2");

    // reset during WAIT discards the poll and the queued event
    poll_push(8'h0B, 8'h11, "pre_rst");
    check_eq("pre_rst_count", {27'd0, dbg_fifo_count}, 32'd1);
    exp_q.delete();
    wait_state(ST_WAIT, "rst_wait");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("midrst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    check_eq("midrst_addr", {30'd0, pio_address}, 32'd3);
    check_eq("midrst_count", {27'd0, dbg_fifo_count}, 32'd0);
    check_eq("midrst_valid", {31'd0, evt_valid}, 32'd0);
    settle(8'h22, "first_after_rst");
    tick();
    check_eq("first_after_rst_none", {31'd0, evt_valid}, 32'd0);
    wait_sample("same_after_rst");
    check_eq("same_after_rst_none", {31'd0, evt_valid}, 32'd0);
    poll_push(8'h22, 8'h33, "post_rst");
    pop_check("post_rst_pop");

    // one-poll glitch 33 -> FF -> 33
`ifdef TESTBENCH_LS_INPUT_POLLER_DEBOUNCE_EN
    pio_readdata = 32'hFF;
    wait_sample("glitch");
    check_eq("glitch_none", {31'd0, evt_valid}, 32'd0);
    pio_readdata = 32'h33;
    wait_sample("glitch_back");
    check_eq("glitch_back_none", {31'd0, evt_valid}, 32'd0);
    wait_sample("glitch_rearm");
    pio_readdata = 32'hFF;
    wait_sample("hold1");
    check_eq("hold1_none", {31'd0, evt_valid}, 32'd0);
    wait_sample("hold2");
    exp_q.push_back(16'h33FF);
    pop_check("hold2_pop");
`else
    pio_readdata = 32'hFF;
    wait_sample("glitch");
    exp_q.push_back(16'h33FF);
    pop_check("glitch_pop");
    pio_readdata = 32'h33;
    wait_sample("glitch_back");
    exp_q.push_back(16'hFF33);
    pop_check("glitch_back_pop");
`endif

    // enable dropped mid-poll: poll completes, then no new poll starts
    wait_state(ST_WAIT, "en_wait");
    enable = 1'b0;
    tick();
    check_eq("en_off_sample", {30'd0, dbg_state}, {30'd0, ST_SAMPLE});
    tick();
    check_eq("en_off_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    seen_addr = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (pio_address == 2'b00) seen_addr = 1'b1;
    end
    check_eq("en_off_no_poll", {31'd0, seen_addr}, 32'd0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/testbench_ls_input_poller.md
TESTBENCH_LS_INPUT_POLLER -- requirements
Module: testbench_ls_input_poller

Interface
REQ-001 The block SHALL have parameter POLL_DIV, default 16, meaning clk cycles between poll starts (legal range 4..65535).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning change-event FIFO entries (power of two, 2..16).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  1 = polling runs; 0 = the poll counter holds and no new poll starts.
REQ-006 pio_address  output  2  address to the 8-bit input PIO slave.
REQ-007 pio_readdata  input  32  PIO read data; registered in the PIO, valid one clk after the address; only bits [7:0] are used.
REQ-008 evt_valid  output  1  FIFO head holds a change event.
REQ-009 evt_data  output  16  {previous value[7:0], new value[7:0]} of the head event.
REQ-010 evt_ready  input  1  consumer pops the head when evt_valid=1.
REQ-011 irq  output  1  level interrupt, equal to evt_valid.
REQ-012 overflow  output  1  sticky flag: an event was dropped.
REQ-013 ovf_clear  input  1  clears overflow.

Function
REQ-014 The FSM SHALL have states IDLE, ADDR, WAIT and SAMPLE.
REQ-015 IDLE: pio_address=2'b11; the poll counter increments while enable=1; at count POLL_DIV-1 the counter clears and the FSM goes to ADDR.
REQ-016 ADDR: pio_address=2'b00 for exactly one cycle, then WAIT.
REQ-017 WAIT: pio_address=2'b11 for one cycle, then SAMPLE.
REQ-018 SAMPLE: capture pio_readdata[7:0] as the sample, then return to IDLE; the poll period is exactly POLL_DIV+3 cycles start-to-start.
REQ-019 The first sample after reset SHALL load the last-accepted register only; it SHALL generate no event.
REQ-020 A later accepted sample that differs from last-accepted SHALL push {last, sample} and update last-accepted in the same cycle; an equal sample SHALL do nothing.
REQ-021 The event SHALL become visible on evt_valid the cycle after SAMPLE (1-cycle latency).
REQ-022 A pop SHALL occur when evt_valid and evt_ready are both 1; evt_data SHALL change only on a pop or on a push into an empty FIFO.
REQ-023 FIFO full with a push and no pop: drop the event, set overflow, still update last-accepted.
REQ-024 FIFO full with a push and a pop in the same cycle: both SHALL be accepted, and overflow SHALL be unchanged.
REQ-025 FIFO empty with a push in the same cycle: accept the push; a pop with evt_valid=0 SHALL be ignored.
REQ-026 The FIFO pointers SHALL wrap modulo FIFO_DEPTH; the occupancy count SHALL be log2(FIFO_DEPTH)+1 bits wide.
REQ-027 ovf_clear=1 SHALL clear overflow; when a set (drop) and ovf_clear occur in the same cycle, set SHALL win.
REQ-028 enable deasserted outside IDLE SHALL NOT abort the current poll; the poll completes.

Reset
REQ-029 Reset SHALL put the FSM in IDLE and set: poll counter=0, pio_address=2'b11, FIFO empty, evt_valid=0, evt_data=0, irq=0, overflow=0, last-accepted=0, first-sample flag set.
REQ-030 Reset asserted mid-poll or mid-pop SHALL take priority; any pending sample SHALL be discarded.

Configuration
REQ-031 With macro TESTBENCH_LS_INPUT_POLLER_DEBOUNCE_EN defined, a sample SHALL be accepted only when it equals the previous raw sample (two consecutive equal polls); the raw-sample register resets to 0.
REQ-032 Without the macro, every sample SHALL be accepted, and no raw-sample register SHALL exist.

Verification
REQ-033 reset, then enable=1 with PIO input 0x5A constant -> pio_address is 00 for one cycle every 19 cycles; no event; irq=0.
REQ-034 input 0x5A->0x3C between polls -> one event with evt_data=0x5A3C, evt_valid rising 1 cycle after SAMPLE, irq=1 until the pop.
REQ-035 evt_ready=0; inputs 01,02,03,04,05 on successive polls (baseline 00) -> FIFO holds 4 events; the 5th (0x0405) is dropped; overflow=1; after draining, the next change 05->06 yields event 0x0506.
REQ-036 FIFO full, change arriving in the same cycle as a pop -> the event is accepted, overflow stays 0, occupancy stays 4.
REQ-037 reset asserted during WAIT -> next cycle FSM=IDLE, pio_address=11, FIFO empty; the following first poll generates no event.
REQ-038 DEBOUNCE_EN defined: input glitch 00->FF for one poll only -> no event; held 00->FF for two polls -> one event 0x00FF after the second.
